vin_testpattern: RTL

//  Internal video source for bring-up without DVI/LVDS. Generates VS/HS/DE timing and a 2-pixel-per-clock
//  8-bit grey test pattern on v_pixel. Sits directly upstream of vi_fifo (write side) and the v_vs sync.

---
 rtl/vin_testpattern.sv | 143 ++++++++++++++
 1 files changed

// File: rtl/vin_testpattern.sv
`default_nettype none
// ============================================================================
// Module      : vin_testpattern
// Description : Internal VS/HS/DE timing and 2-pixel-per-clock grey test
//               pattern source. Optional VIN_TPG_SCROLL_EN scrolls patterns
//               by the completed-frame count.
// Revision    : 1.0 - initial release
// ============================================================================
module vin_testpattern #(
  parameter int H_ACT  = 800,
  parameter int H_FP   = 32,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 152,
  parameter int V_ACT  = 1200,
  parameter int V_FP   = 1,
  parameter int V_SYNC = 3,
  parameter int V_BP   = 46
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        enable,
  input  logic [1:0]  pattern,
  output logic        v_pclk,
  output logic        v_vsync,
  output logic        v_hsync,
  output logic        v_de,
  output logic [15:0] v_pixel,
  output logic [7:0]  frame_cnt
);

  localparam logic [11:0] H_ACT_C   = 12'(H_ACT);
  localparam logic [11:0] H_SS_C    = 12'(H_ACT + H_FP);
  localparam logic [11:0] H_SE_C    = 12'(H_ACT + H_FP + H_SYNC);
  localparam logic [11:0] H_LAST_C  = 12'(H_ACT + H_FP + H_SYNC + H_BP - 1);
  localparam logic [11:0] V_ACT_C   = 12'(V_ACT);
  localparam logic [11:0] V_SS_C    = 12'(V_ACT + V_FP);
  localparam logic [11:0] V_SE_C    = 12'(V_ACT + V_FP + V_SYNC);
  localparam logic [11:0] V_LAST_C  = 12'(V_ACT + V_FP + V_SYNC + V_BP - 1);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RUN      = 2'd1,
    STOPPING = 2'd2
  } state_t;

  state_t      state;
  logic [11:0] hcnt;
  logic [11:0] vcnt;
  logic [1:0]  pat_q;

  logic        line_end;
  logic        frame_end;
  logic        frame_start;
  logic        active;
  logic        hs_win;
  logic        vs_win;
  logic [1:0]  pat_cur;
  logic [7:0]  xb;
  logic [7:0]  yb;
  logic [15:0] pix;

  assign v_pclk      = clk;
  assign line_end    = (hcnt == H_LAST_C);
  assign frame_end   = line_end && (vcnt == V_LAST_C);
  assign frame_start = (hcnt == 12'd0) && (vcnt == 12'd0);
  assign active      = (hcnt < H_ACT_C) && (vcnt < V_ACT_C);
  assign hs_win      = (hcnt >= H_SS_C) && (hcnt < H_SE_C);
  assign vs_win      = (vcnt >= V_SS_C) && (vcnt < V_SE_C);
  // The pattern sampled at frame start must already drive that first pixel.
  assign pat_cur     = frame_start ? pattern : pat_q;

  // Only the low byte of x and y is ever visible, so offsets are added mod 256.
`ifdef VIN_TPG_SCROLL_EN
  assign xb = {hcnt[6:0], 1'b0} + {frame_cnt[6:0], 1'b0};
  assign yb = vcnt[7:0] + frame_cnt;
`else
  assign xb = {hcnt[6:0], 1'b0};
  assign yb = vcnt[7:0];
`endif

  always_comb begin
    pix = 16'h0000;
    case (pat_cur)
      2'd0:    pix = {xb[7:1], 1'b1, xb};
      2'd1:    pix = {16{xb[3] ^ yb[3]}};
      2'd2:    pix = {yb, yb};
      default: pix = 16'hFFFF;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hcnt      <= 12'd0;
      vcnt      <= 12'd0;
      pat_q     <= 2'd0;
      frame_cnt <= 8'd0;
      v_vsync   <= 1'b0;
      v_hsync   <= 1'b0;
      v_de      <= 1'b0;
      v_pixel   <= 16'h0000;
    end else begin
      case (state)
        RUN, STOPPING: begin
          v_de    <= active;
          v_hsync <= hs_win;
          v_vsync <= vs_win;
          v_pixel <= active ? pix : 16'h0000;
          if (frame_start) pat_q <= pattern;
          if (line_end) begin
            hcnt <= 12'd0;
            vcnt <= frame_end ? 12'd0 : vcnt + 12'd1;
          end else begin
            hcnt <= hcnt + 12'd1;
          end
          if (frame_end) frame_cnt <= frame_cnt + 8'd1;
          if (enable)
            state <= RUN;
          else if (state == STOPPING && frame_end)
            state <= IDLE;
          else
            state <= STOPPING;
        end
        default: begin
          hcnt    <= 12'd0;
          vcnt    <= 12'd0;
          v_de    <= 1'b0;
          v_hsync <= 1'b0;
          v_vsync <= 1'b0;
          v_pixel <= 16'h0000;
          if (enable) begin
            state <= RUN;
            pat_q <= pattern;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
`default_nettype wire
